// File: rtl/lvds_rx_pkg.sv
// Shared definitions for the LVDS receive path: the PLL phase-step state
// machine encoding and the PLL counter-select codes.
package lvds_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PULSE     = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_HIGH = 3'd3,
    ST_GAP       = 3'd4,
    ST_FINISH    = 3'd5
  } phase_state_t;

  // PLL counter select: C0 drives the fast serial clock, C1 the slow parallel clock
  localparam logic [4:0] CNTSEL_C0 = 5'd0;
  localparam logic [4:0] CNTSEL_C1 = 5'd1;

  // Width of the per-step timeout counter (covers the largest legal timeout)
  localparam int TMO_W = 16;

endpackage

// File: rtl/lvds_sync2.sv
// Two-flop synchronizer for asynchronous level signals, with a selectable
// reset value so idle-high inputs do not glitch low out of reset.
module lvds_sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_p0;
  logic [W-1:0] sync_p1;

  // Metastability capture, then one more flop before any decision logic
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/lvds_pll_phase_ctrl.sv
// Drives the PLL dynamic phase-shift handshake: issues a requested number of
// phase_en pulses in one direction on one counter, waits for phase_done to
// cycle low/high after each, tracks the net signed phase position and flags
// lock loss or handshake timeouts.
module lvds_pll_phase_ctrl
  import lvds_rx_pkg::*;
#(
  parameter int PULSE_CYC   = 2,
  parameter int TIMEOUT_CYC = 255,
  parameter int STEP_W      = 6,
  parameter int POS_W       = 8
) (
  input  logic                    scanclk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    req_up,
  input  logic [STEP_W-1:0]       req_steps,
  input  logic [4:0]              req_cntsel,
  input  logic                    locked,
  input  logic                    phase_done,
  output logic                    phase_en,
  output logic                    updn,
  output logic [4:0]              cntsel,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic signed [POS_W-1:0] phase_pos
);

  localparam logic [TMO_W-1:0] PULSE_LAST = TMO_W'(PULSE_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);

  phase_state_t      state;
  logic [STEP_W-1:0] remaining;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              sync_lock;
  logic              sync_done;

  // One phase step in the latched direction, wrapping modulo 2^POS_W
  function automatic logic signed [POS_W-1:0] step_pos(
    input logic signed [POS_W-1:0] pos,
    input logic                    up
  );
    return up ? POS_W'(pos + 1) : POS_W'(pos - 1);
  endfunction

  lvds_sync2 #(.W(1), .RST_VAL(1'b0)) u_sync_lock (
    .clk (scanclk),
    .rst (rst),
    .d   (locked),
    .q   (sync_lock)
  );

  lvds_sync2 #(.W(1), .RST_VAL(1'b1)) u_sync_done (
    .clk (scanclk),
    .rst (rst),
    .d   (phase_done),
    .q   (sync_done)
  );

  // Phase-step sequencer; every output is registered on the transition into its state
  always_ff @(posedge scanclk) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase_en  <= 1'b0;
      updn      <= 1'b0;
      cntsel    <= CNTSEL_C0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      phase_pos <= '0;
      remaining <= '0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            updn      <= req_up;
            cntsel    <= req_cntsel;
            remaining <= req_steps;
            err       <= 1'b0;
            busy      <= 1'b1;
            if (!sync_lock) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= ST_FINISH;
            end else if (req_steps == '0) begin
              done  <= 1'b1;
              state <= ST_FINISH;
            end else begin
              phase_en <= 1'b1;
              tmo_cnt  <= '0;
              state    <= ST_PULSE;
            end
          end
        end

        ST_PULSE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (tmo_cnt == PULSE_LAST) begin
            phase_en <= 1'b0;
            state    <= ST_WAIT_LOW;
          end
        end

        ST_WAIT_LOW: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (tmo_cnt >= TMO_LAST) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= ST_FINISH;
          end else if (!sync_done) begin
            state <= ST_WAIT_HIGH;
          end
        end

        ST_WAIT_HIGH: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (sync_done) begin
            phase_pos <= step_pos(phase_pos, updn);
            remaining <= remaining - 1'b1;
            state     <= ST_GAP;
          end else if (tmo_cnt >= TMO_LAST) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= ST_FINISH;
          end
        end

        ST_GAP: begin
          if (remaining == '0) begin
            done  <= 1'b1;
            state <= ST_FINISH;
          end else if (!sync_lock) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= ST_FINISH;
          end else begin
            phase_en <= 1'b1;
            tmo_cnt  <= '0;
            state    <= ST_PULSE;
          end
        end

        ST_FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          phase_en <= 1'b0;
          done     <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lvds_pll_phase_ctrl.sv
// Scoreboard bench for lvds_pll_phase_ctrl: a behavioural PLL answers each
// phase_en pulse, each request pushes its expected outcome, and a negedge
// monitor checks pulses and every done pulse against the queue.
module tb_lvds_pll_phase_ctrl;

  localparam int PULSE_CYC   = 2;
  localparam int TIMEOUT_CYC = 255;
  localparam int STEP_W      = 6;
  localparam int POS_W       = 8;

  logic                    scanclk;
  logic                    rst;
  logic                    req;
  logic                    req_up;
  logic [STEP_W-1:0]       req_steps;
  logic [4:0]              req_cntsel;
  logic                    locked;
  logic                    phase_done;
  logic                    phase_en;
  logic                    updn;
  logic [4:0]              cntsel;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic signed [POS_W-1:0] phase_pos;

  lvds_pll_phase_ctrl #(
    .PULSE_CYC   (PULSE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .STEP_W      (STEP_W),
    .POS_W       (POS_W)
  ) dut (
    .scanclk    (scanclk),
    .rst        (rst),
    .req        (req),
    .req_up     (req_up),
    .req_steps  (req_steps),
    .req_cntsel (req_cntsel),
    .locked     (locked),
    .phase_done (phase_done),
    .phase_en   (phase_en),
    .updn       (updn),
    .cntsel     (cntsel),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .phase_pos  (phase_pos)
  );

  typedef struct {
    logic signed [POS_W-1:0] pos;
    bit                      err;
    int                      pulses;
    bit                      up;
    logic [4:0]              cs;
    bit                      tmo;
  } exp_t;

  exp_t                    sb[$];
  int                      n_chk  = 0;
  int                      n_fail = 0;
  int                      cyc    = 0;
  int                      pll_rises = 0;
  bit                      pll_hang  = 0;
  logic signed [POS_W-1:0] model_pos = '0;

  initial scanclk = 1'b0;
  always #5 scanclk = ~scanclk;

  always @(posedge scanclk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Behavioural PLL: phase_done falls 3 cycles after a phase_en rise and returns 4 cycles later
  initial begin
    int  t;
    bit  pe_prev;
    t = 0;
    pe_prev = 1'b0;
    phase_done = 1'b1;
    forever begin
      @(posedge scanclk);
      #1;
      if (phase_en && !pe_prev) begin
        pll_rises++;
        if (!pll_hang) t = 1;
      end else if (t > 0) begin
        t++;
      end
      if (t == 3) phase_done = 1'b0;
      if (t == 7) begin
        phase_done = 1'b1;
        t = 0;
      end
      pe_prev = phase_en;
    end
  end

  // Monitor: pulse shape and direction while stepping, outcome on every done
  initial begin
    exp_t e;
    bit   pe_q;
    int   plen;
    int   pseen;
    int   rise_cyc;
    pe_q = 1'b0;
    plen = 0;
    pseen = 0;
    rise_cyc = 0;
    forever begin
      @(negedge scanclk);
      if (rst) begin
        pe_q = 1'b0;
        plen = 0;
        pseen = 0;
      end else begin
        if (phase_en) begin
          if (!pe_q) rise_cyc = cyc;
          plen++;
          check("busy_while_phase_en", busy, 1);
          if (sb.size() > 0) begin
            check("updn_during_pulse", updn, sb[0].up);
            check("cntsel_during_pulse", cntsel, sb[0].cs);
          end
        end else if (pe_q) begin
          check("pulse_width", plen, PULSE_CYC);
          plen = 0;
          pseen++;
        end
        pe_q = phase_en;
        if (done) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            check("phase_pos", phase_pos, e.pos);
            check("err", err, e.err);
            check("pulse_count", pseen, e.pulses);
            check("busy_at_done", busy, 1);
            if (e.tmo) check("timeout_latency", cyc - rise_cyc, TIMEOUT_CYC);
          end
          pseen = 0;
        end
      end
    end
  end

  // Issue one request, record its expected outcome, and wait for the scoreboard to drain
  task automatic do_req(input bit up, input int steps, input logic [4:0] cs,
                        input bit lock_ok, input bit hang, input int drop, input bit poke);
    exp_t e;
    int   base;
    int   k;
    k = 0;
    while (busy && k < 1000) begin
      @(negedge scanclk);
      k++;
    end
    if (!lock_ok) begin
      locked = 1'b0;
      repeat (4) @(negedge scanclk);
    end
    pll_hang = hang;
    e.up = up;
    e.cs = cs;
    e.tmo = 1'b0;
    if (!lock_ok) begin
      e.err = 1'b1; e.pulses = 0;
    end else if (steps == 0) begin
      e.err = 1'b0; e.pulses = 0;
    end else if (hang) begin
      e.err = 1'b1; e.pulses = 1; e.tmo = 1'b1;
    end else if (drop > 0 && drop < steps) begin
      e.err = 1'b1; e.pulses = drop;
    end else begin
      e.err = 1'b0; e.pulses = steps;
    end
    if (!hang) model_pos = POS_W'(int'(model_pos) + (up ? e.pulses : -e.pulses));
    e.pos = model_pos;
    sb.push_back(e);
    base = pll_rises;
    req = 1'b1;
    req_up = up;
    req_steps = STEP_W'(steps);
    req_cntsel = cs;
    @(negedge scanclk);
    req = 1'b0;
    req_steps = '0;
    if (drop > 0) begin
      k = 0;
      while (pll_rises - base < drop && k < 1000) begin
        @(negedge scanclk);
        k++;
      end
      locked = 1'b0;
    end
    if (poke) begin
      repeat (5) @(negedge scanclk);
      req = 1'b1;
      req_up = ~up;
      req_steps = STEP_W'(7);
      @(negedge scanclk);
      req = 1'b0;
      req_steps = '0;
    end
    k = 0;
    while (sb.size() > 0 && k < 3000) begin
      @(negedge scanclk);
      k++;
    end
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected a completion", k);
      sb.delete();
    end
    locked = 1'b1;
    pll_hang = 1'b0;
    repeat (4) @(negedge scanclk);
  endtask

  initial begin
    int k;
    int st;
    int dr;
    bit lk;
    rst = 1'b1;
    req = 1'b0;
    req_up = 1'b0;
    req_steps = '0;
    req_cntsel = '0;
    locked = 1'b1;
    repeat (3) @(negedge scanclk);
    check("rst_phase_en", phase_en, 0);
    check("rst_updn", updn, 0);
    check("rst_cntsel", cntsel, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_phase_pos", phase_pos, 0);
    rst = 1'b0;
    repeat (5) @(negedge scanclk);

    do_req(1'b1, 3, 5'd0, 1'b1, 1'b0, 0, 1'b0);   // +3
    do_req(1'b0, 5, 5'd0, 1'b1, 1'b0, 0, 1'b0);   // -2
    check("pos_after_down", phase_pos, -2);
    do_req(1'b1, 3, 5'd1, 1'b1, 1'b0, 0, 1'b1);   // busy request ignored, +1
    do_req(1'b1, 63, 5'd0, 1'b1, 1'b0, 0, 1'b0);  // 64
    do_req(1'b1, 63, 5'd0, 1'b1, 1'b0, 0, 1'b0);  // 127
    check("pos_at_max", phase_pos, 127);
    do_req(1'b1, 1, 5'd0, 1'b1, 1'b0, 0, 1'b0);   // wraps to -128
    check("pos_wrapped", phase_pos, -128);
    do_req(1'b0, 3, 5'd1, 1'b0, 1'b0, 0, 1'b0);   // no lock at request
    do_req(1'b1, 0, 5'd1, 1'b1, 1'b0, 0, 1'b0);   // zero steps clears err
    do_req(1'b1, 4, 5'd0, 1'b1, 1'b0, 2, 1'b0);   // lock lost during step 2
    do_req(1'b0, 2, 5'd1, 1'b1, 1'b1, 0, 1'b0);   // PLL never answers

    for (int i = 0; i < 16; i++) begin
      st = $urandom_range(0, 6);
      lk = ($urandom_range(0, 7) != 0);
      if (!lk && st == 0) st = 1;
      dr = 0;
      if (lk && st >= 2 && $urandom_range(0, 4) == 0) dr = $urandom_range(1, st - 1);
      repeat ($urandom_range(0, 3)) @(negedge scanclk);
      do_req(1'($urandom_range(0, 1)), st, 5'($urandom_range(0, 31)), lk, 1'b0, dr, 1'b0);
    end

    // Reset in the middle of a step while waiting for phase_done to return high
    sb.push_back('{pos: model_pos, err: 1'b0, pulses: 4, up: 1'b1, cs: 5'd1, tmo: 1'b0});
    req = 1'b1;
    req_up = 1'b1;
    req_steps = STEP_W'(4);
    req_cntsel = 5'd1;
    @(negedge scanclk);
    req = 1'b0;
    k = 0;
    while (!phase_en && k < 100) begin @(negedge scanclk); k++; end
    while (phase_en && k < 100) begin @(negedge scanclk); k++; end
    check("phase_en_seen_before_rst", k < 100, 1);
    repeat (3) @(negedge scanclk);
    rst = 1'b1;
    @(negedge scanclk);
    sb.delete();
    model_pos = '0;
    check("midrst_phase_en", phase_en, 0);
    check("midrst_updn", updn, 0);
    check("midrst_cntsel", cntsel, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    check("midrst_phase_pos", phase_pos, 0);
    rst = 1'b0;
    repeat (10) @(negedge scanclk);
    do_req(1'b0, 2, 5'd0, 1'b1, 1'b0, 0, 1'b0);
    check("pos_after_rst_run", phase_pos, -2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lvds_pll_phase_ctrl.md
LVDS_PLL_PHASE_CTRL -- requirements
Module: lvds_pll_phase_ctrl

Interface
REQ-001 Parameter PULSE_CYC, default 2: scanclk cycles phase_en is held high per step (legal 1..7).
REQ-002 Parameter TIMEOUT_CYC, default 255: maximum scanclk cycles allowed from phase_en rise to phase_done return-high, per step (legal 16..65535).
REQ-003 Parameter STEP_W, default 6: width of the requested step count.
REQ-004 Parameter POS_W, default 8: width of the signed net phase position.
REQ-005 Port scanclk, in, 1: sole clock; the PLL dynamic-phase-shift clock.
REQ-006 Port rst, in, 1: reset, synchronous, active-high.
REQ-007 Port req, in, 1: start request, sampled in IDLE only.
REQ-008 Port req_up, in, 1: direction (1 = up/advance, 0 = down).
REQ-009 Port req_steps, in, STEP_W: number of phase steps to perform.
REQ-010 Port req_cntsel, in, 5: PLL counter select to shift.
REQ-011 Port locked, in, 1: PLL lock, asynchronous.
REQ-012 Port phase_done, in, 1: PLL phase-done, asynchronous, idle high.
REQ-013 Port phase_en, out, 1: to PLL phase_en.
REQ-014 Port updn, out, 1: to PLL updn.
REQ-015 Port cntsel, out, 5: to PLL cntsel.
REQ-016 Port busy, out, 1: high whenever state is not IDLE.
REQ-017 Port done, out, 1: one-cycle completion pulse.
REQ-018 Port err, out, 1: sticky error flag; cleared on next accepted req or on rst.
REQ-019 Port phase_pos, out, POS_W: signed net steps completed since reset.

Function
REQ-020 locked and phase_done SHALL each pass through a 2-flop synchronizer; all decisions use the synchronized values (sync_done, sync_lock).
REQ-021 States: IDLE, PULSE, WAIT_LOW, WAIT_HIGH, GAP, FINISH.
REQ-022 IDLE, req=1, sync_lock=1, req_steps>0: latch direction, cntsel and step count; enter PULSE; clear err.
REQ-023 IDLE, req=1, req_steps=0: enter FINISH; no phase_en activity.
REQ-024 IDLE, req=1, sync_lock=0: set err; enter FINISH.
REQ-025 updn and cntsel SHALL be registered from the latched values in the cycle req is accepted and held stable until the next accepted req.
REQ-026 PULSE: phase_en=1 for exactly PULSE_CYC cycles, the first being the cycle after req acceptance; then WAIT_LOW.
REQ-027 WAIT_LOW: sync_done=0 -> WAIT_HIGH; WAIT_HIGH: sync_done=1 -> step complete.
REQ-028 Step complete: phase_pos += 1 (up) or -= 1 (down), two's-complement wrap modulo 2^POS_W; remaining decrements; enter GAP.
REQ-029 GAP lasts 1 cycle; then remaining>0 and sync_lock=1 -> PULSE; remaining=0 -> FINISH; sync_lock=0 -> set err, FINISH.
REQ-030 Timeout counter clears on PULSE entry and counts through PULSE/WAIT_LOW/WAIT_HIGH; reaching TIMEOUT_CYC sets err, enters FINISH, phase_pos unchanged for that step.
REQ-031 FINISH lasts 1 cycle with done=1; then IDLE.
REQ-032 req while busy=1 SHALL be ignored (no queuing).
REQ-033 phase_en SHALL be 0 in every state except PULSE.

Reset
REQ-034 On rst: state IDLE, phase_en=0, updn=0, cntsel=0, busy=0, done=0, err=0, phase_pos=0, synchronizers=0 (lock) and 1 (done), counters=0.
REQ-035 rst asserted mid-operation SHALL take effect on the next edge; phase_en is 0 in the following cycle; no done pulse.

Structure
REQ-036 Shared package lvds_rx_pkg SHALL hold the state enumeration and the cntsel encoding constants (CNTSEL_C0 = 5'd0 fast clock, CNTSEL_C1 = 5'd1 slow clock).
REQ-037 One sub-module, lvds_sync2 (2-flop synchronizer, width parameter), instantiated for locked and phase_done.

Verification
REQ-038 PLL model returns phase_done low 3 cycles after phase_en, high 4 cycles later; req_up=1, req_steps=3, cntsel=0 -> three 2-cycle phase_en pulses, done once, phase_pos=3, err=0.
REQ-039 From phase_pos=3: req_up=0, req_steps=5 -> phase_pos=-2 (8'hFE), updn=0 throughout.
REQ-040 phase_pos=127, req_up=1, req_steps=1 -> phase_pos=-128 (wrap), no err.
REQ-041 Model never drops phase_done, req_steps=2 -> err=1 and done at cycle TIMEOUT_CYC after phase_en rise; phase_pos unchanged; one phase_en pulse only.
REQ-042 locked=0 at req -> err=1, done pulse, no phase_en; locked drops during step 2 of 4 -> step 2 completes, err, phase_pos +2.
REQ-043 rst during WAIT_HIGH -> next cycle all outputs at reset values; req while busy ignored (step count unchanged).
